// File: rtl/dac_stream_feeder.sv
// dac_stream_feeder: FIFO-buffered DAC0/DAC1 sample sequencer with priming, offset, saturation and underflow status
module dac_stream_feeder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PRIME_LEVEL = 8
) (
  input  logic               clkD,
  input  logic               rst_in,
  input  logic               enable_in,
  input  logic               flush_in,
  input  logic               clr_status_in,
  input  logic               s_valid_in,
  output logic               s_ready_out,
  input  logic signed [15:0] s_dac0_in,
  input  logic signed [15:0] s_dac1_in,
  input  logic signed [15:0] offset0_in,
  input  logic signed [15:0] offset1_in,
  output logic signed [15:0] DAC0_out,
  output logic signed [15:0] DAC1_out,
  output logic               running_out,
  output logic [DEPTH_LOG2:0] fill_out,
  output logic               underflow_out,
  output logic [15:0]        underflow_cnt_out
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;
  state_t state, state_nx;
  logic [CW-1:0] count;
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [31:0] mem [DEPTH];
  logic [31:0] rd;
  logic push, pop, under, active, empty;
  function automatic logic [15:0] sat(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {a[15], a} + {b[15], b};
    return (s[16] ^ s[15]) ? (s[16] ? 16'h8000 : 16'h7FFF) : s[15:0];
  endfunction
  assign s_ready_out = count < CW'(DEPTH);
  assign empty = count == '0;
  assign active = enable_in && !flush_in && state == RUN;
  assign pop = active && !empty;
  assign under = active && empty;
  assign push = s_valid_in && s_ready_out && !flush_in;
  assign rd = mem[rptr];
  assign running_out = state == RUN;
  assign fill_out = count;
  always_comb begin
    state_nx = state;
    state_nx = !enable_in ? IDLE :
               flush_in ? PRIME :
               state == IDLE ? PRIME :
               (state == PRIME && count >= CW'(PRIME_LEVEL)) ? RUN :
               under ? PRIME : state;
  end
  always_ff @(posedge clkD or posedge rst_in)
    if (rst_in) begin
      state <= IDLE;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      state <= state_nx;
      count <= flush_in ? '0 : count + CW'(push) - CW'(pop);
      wptr <= flush_in ? '0 : wptr + DEPTH_LOG2'(push);
      rptr <= flush_in ? '0 : rptr + DEPTH_LOG2'(pop);
    end
  always_ff @(posedge clkD)
    if (push) mem[wptr] <= {s_dac1_in, s_dac0_in};
  // IDLE and enable-drop force zero; otherwise outputs only move on a pop
  always_ff @(posedge clkD or posedge rst_in)
    if (rst_in) begin
      DAC0_out <= '0;
      DAC1_out <= '0;
    end else if (!enable_in || state == IDLE) begin
      DAC0_out <= '0;
      DAC1_out <= '0;
    end else if (pop) begin
      DAC0_out <= sat(rd[15:0], offset0_in);
      DAC1_out <= sat(rd[31:16], offset1_in);
    end
  always_ff @(posedge clkD or posedge rst_in)
    if (rst_in) begin
      underflow_out <= 1'b0;
      underflow_cnt_out <= '0;
    end else if (clr_status_in) begin
      underflow_out <= 1'b0;
      underflow_cnt_out <= '0;
    end else if (under) begin
      underflow_out <= 1'b1;
      underflow_cnt_out <= underflow_cnt_out + 16'(underflow_cnt_out != 16'hFFFF);
    end
endmodule

// File: tb/tb_dac_stream_feeder.sv
// tb_dac_stream_feeder: queue-based reference model checked every cycle under directed and random stimulus
module tb_dac_stream_feeder;
  logic clkD = 0, rst_in = 1, enable_in = 0, flush_in = 0, clr_status_in = 0, s_valid_in = 0;
  logic [15:0] s_dac0_in = 0, s_dac1_in = 0, offset0_in = 0, offset1_in = 0;
  logic s_ready_out, running_out, underflow_out;
  logic [15:0] DAC0_out, DAC1_out, underflow_cnt_out;
  logic [4:0] fill_out;
  int errors = 0, checks = 0;
  logic [31:0] q[$];
  int mode;
  logic [15:0] e0, e1, eufc;
  logic euf;
  dac_stream_feeder dut (
    .clkD(clkD), .rst_in(rst_in), .enable_in(enable_in), .flush_in(flush_in),
    .clr_status_in(clr_status_in), .s_valid_in(s_valid_in), .s_ready_out(s_ready_out),
    .s_dac0_in(s_dac0_in), .s_dac1_in(s_dac1_in), .offset0_in(offset0_in), .offset1_in(offset1_in),
    .DAC0_out(DAC0_out), .DAC1_out(DAC1_out), .running_out(running_out), .fill_out(fill_out),
    .underflow_out(underflow_out), .underflow_cnt_out(underflow_cnt_out)
  );
  always #5 clkD = ~clkD;
  function automatic logic [15:0] sat(logic [15:0] a, logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    mode = 0; e0 = 0; e1 = 0; euf = 0; eufc = 0;
  endtask
  task automatic compare();
    chk("dac0", DAC0_out, e0);
    chk("dac1", DAC1_out, e1);
    chk("running", running_out, mode == 2);
    chk("fill", fill_out, q.size());
    chk("ready", s_ready_out, q.size() < 16);
    chk("uf", underflow_out, euf);
    chk("ufcnt", underflow_cnt_out, eufc);
  endtask
  task automatic step();
    int n;
    logic push, run_ok, under;
    logic [31:0] w;
    n = q.size();
    push = s_valid_in && n < 16 && !flush_in;
    run_ok = enable_in && !flush_in && mode == 2;
    under = run_ok && n == 0;
    if (!enable_in || mode == 0) begin e0 = 0; e1 = 0; end
    if (flush_in) q.delete();
    else begin
      if (run_ok && n != 0) begin
        w = q.pop_front();
        e0 = sat(w[15:0], offset0_in);
        e1 = sat(w[31:16], offset1_in);
      end
      if (push) q.push_back({s_dac1_in, s_dac0_in});
    end
    mode = !enable_in ? 0 : flush_in ? 1 : mode == 0 ? 1 : (mode == 1 && n >= 8) ? 2 : under ? 1 : mode;
    if (clr_status_in) begin euf = 0; eufc = 0; end
    else if (under) begin euf = 1; if (eufc != 16'hFFFF) eufc++; end
  endtask
  task automatic cycle();
    if (rst_in) model_reset(); else step();
    @(posedge clkD);
    #1;
    compare();
  endtask
  task automatic rnd_data();
    s_dac0_in = 16'($urandom);
    s_dac1_in = 16'($urandom);
  endtask
  initial begin
    #2;
    model_reset();
    compare();
    cycle();
    rst_in = 0;
    cycle();
    enable_in = 1;
    for (int k = 1; k <= 20; k++) begin
      s_valid_in = 1; s_dac0_in = 16'(k); s_dac1_in = 16'(-k);
      cycle();
    end
    s_valid_in = 0;
    repeat (20) cycle();
    chk("uf_after_stream", underflow_out, 1'b1);
    offset0_in = 16'h7000; offset1_in = 16'h8000;
    repeat (10) begin
      s_valid_in = 1; s_dac0_in = 16'h2000; s_dac1_in = 16'hF000;
      cycle();
    end
    s_valid_in = 0;
    repeat (12) cycle();
    chk("sat_hold0", DAC0_out, 16'h7FFF);
    chk("sat_hold1", DAC1_out, 16'h8000);
    clr_status_in = 1;
    cycle();
    clr_status_in = 0;
    chk("clr_uf", underflow_out, 1'b0);
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 0) begin
        offset0_in = 16'($urandom);
        offset1_in = (i % 128 == 0) ? 16'h0000 : 16'($urandom_range(0, 255));
      end
      s_valid_in = $urandom_range(0, 4) != 0;
      rnd_data();
      enable_in = $urandom_range(0, 60) != 0;
      flush_in = $urandom_range(0, 70) == 0;
      clr_status_in = $urandom_range(0, 40) == 0;
      cycle();
    end
    flush_in = 0; clr_status_in = 0;
    offset0_in = 0; offset1_in = 0;
    enable_in = 0; s_valid_in = 1;
    repeat (22) begin rnd_data(); cycle(); end
    chk("bp_ready", s_ready_out, 1'b0);
    chk("bp_fill", fill_out, 5'd16);
    enable_in = 1;
    repeat (40) begin rnd_data(); cycle(); end
    s_valid_in = 0;
    repeat (3) cycle();
    enable_in = 0;
    cycle();
    chk("drop_dac0", DAC0_out, 16'h0000);
    chk("drop_run", running_out, 1'b0);
    s_valid_in = 0;
    cycle();
    flush_in = 1; s_valid_in = 1; rnd_data();
    cycle();
    flush_in = 0; s_valid_in = 0;
    chk("flush_fill", fill_out, 5'd0);
    enable_in = 1; s_valid_in = 1;
    repeat (14) begin rnd_data(); cycle(); end
    #2 rst_in = 1;
    #1 model_reset();
    compare();
    cycle();
    rst_in = 0;
    s_valid_in = 0;
    repeat (3) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
